// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubble insertion, taken-branch flush,
// multicycle EX freeze, plus saturating stall/flush statistics.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_LATENCY   = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_mc_op,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MC_WAIT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             load_use_s;
  logic             stall_inc_s;
  logic             flush_inc_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign load_use_s = ex_MemRead & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      stall_q <= {CNT_W{1'b0}};
      flush_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_inc_s = 1'b0;
    flush_inc_s = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          flush_inc_s = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = 4'(FLUSH_CYCLES - 1);
          end else begin
            state_d = RUN;
          end
        end else if (id_mc_op) begin
          state_d = MC_WAIT;
          cnt_d   = 4'(MC_LATENCY - 1);
        end else if (load_use_s) begin
          stall_inc_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      // ID contents are being discarded here, so hazards and mc ops are ignored
      FLUSH: begin
        if (branch_taken) begin
          flush_inc_s = 1'b1;
          cnt_d       = 4'(FLUSH_CYCLES - 1);
        end else if (cnt_q == 4'd1) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MC_WAIT: begin
        stall_inc_s = 1'b1;
        if (cnt_q == 4'd1) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
    stall_d = stall_inc_s ? sat_inc(stall_q) : stall_q;
    flush_d = flush_inc_s ? sat_inc(flush_q) : flush_q;
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    busy         = (state_q != RUN);
    if (!reset_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      id_ex_bubble = 1'b1;
      busy         = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (id_mc_op) begin
            id_ex_bubble = 1'b0;
          end else if (load_use_s) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else begin
            id_ex_bubble = 1'b0;
          end
        end
        FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        MC_WAIT: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
        end
        default: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
        end
      endcase
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
